// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C temperature-sensor target: FSM encoding,
// default LM75 address and the transmit-bit selector.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    TX,
    TX_ACK,
    RX,
    RX_ACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic [6:0] LM75_ADDR = 7'h48;

  // Bit idx of the selected byte of the 16-bit shadow word.
  function automatic logic tx_bit(input logic [15:0] word,
                                  input logic        lsb_sel,
                                  input logic [2:0]  idx);
    logic [7:0] byte_v;
    byte_v = lsb_sel ? word[7:0] : word[15:8];
    return byte_v[idx];
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus line plus rise/fall
// detection on the synchronized level. STAGES must be at least 2.
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Idle I2C lines are high, so flops come out of reset at 1 to avoid
  // phantom edges right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value,
      // so the chain really is STAGES flops deep.
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_temp_slave.sv
// I2C target serving a 16-bit temperature word (MSB byte first) and
// accepting written bytes into ptr_reg. SDA is open-drain: 0 or z only.
module i2c_temp_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = LM75_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] temp_data,
  output logic [7:0]  ptr_reg,
  output logic        wr_strobe,
  output logic        rd_done,
  output logic        busy
);

  i2c_state_e  state, state_nxt;
  logic        scl_s, scl_rise, scl_fall;
  logic        sda_s, sda_rise, sda_fall;
  logic        start_det, stop_det;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg, addr_byte;
  logic [15:0] shadow;
  logic        lsb_sel, rw_q, tx_acked, sda_oe;
  logic        oe_nxt, addr_match, ptr_load, rd_pulse, byte_adv, shift_en;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst_n(rst_n), .din(scl),
    .level(scl_s), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst_n(rst_n), .din(sda),
    .level(sda_s), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;
  assign addr_byte = {shift_reg[6:0], sda_s};
  assign shift_en  = scl_rise && (state == ADDR || state == RX);
  assign sda       = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // In the two ACK states sda_oe doubles as the phase flag: the first SCL
  // fall starts driving, the second one releases and moves on.
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise the
    // paths that skip an assignment would infer latches.
    state_nxt  = state;
    oe_nxt     = sda_oe;
    addr_match = 1'b0;
    ptr_load   = 1'b0;
    rd_pulse   = 1'b0;
    byte_adv   = 1'b0;
    case (state)
      IDLE, WAIT_STOP: oe_nxt = 1'b0;
      ADDR: if (scl_rise && bit_cnt == 3'd7) begin
        if (addr_byte[7:1] == DEV_ADDR) begin
          addr_match = 1'b1;
          state_nxt  = ACK_ADDR;
        end else begin
          state_nxt  = WAIT_STOP;
        end
      end
      ACK_ADDR: if (scl_fall) begin
        if (!sda_oe) begin
          oe_nxt = 1'b1;
        end else if (rw_q) begin
          state_nxt = TX;
          oe_nxt    = ~tx_bit(shadow, lsb_sel, 3'd7);
        end else begin
          state_nxt = RX;
          oe_nxt    = 1'b0;
        end
      end
      TX: if (scl_fall) begin
        if (bit_cnt == 3'd7) begin
          state_nxt = TX_ACK;
          oe_nxt    = 1'b0;
        end else begin
          oe_nxt = ~tx_bit(shadow, lsb_sel, 3'd6 - bit_cnt);
        end
      end
      TX_ACK: begin
        if (scl_rise && sda_s) begin
          rd_pulse  = 1'b1;
          state_nxt = WAIT_STOP;
        end else if (scl_fall && tx_acked) begin
          byte_adv  = 1'b1;
          state_nxt = TX;
          oe_nxt    = ~tx_bit(shadow, ~lsb_sel, 3'd7);
        end
      end
      RX: if (scl_rise && bit_cnt == 3'd7) state_nxt = RX_ACK;
      RX_ACK: if (scl_fall) begin
        if (!sda_oe) begin
          oe_nxt   = 1'b1;
          ptr_load = 1'b1;
        end else begin
          oe_nxt    = 1'b0;
          state_nxt = RX;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Bus conditions override everything; STOP wins over a glitch START.
    if (start_det || stop_det) begin
      state_nxt  = stop_det ? IDLE : ADDR;
      oe_nxt     = 1'b0;
      addr_match = 1'b0;
      ptr_load   = 1'b0;
      rd_pulse   = 1'b0;
      byte_adv   = 1'b0;
    end
  end

  // TX counts SCL falls (bit presentation), ADDR/RX count SCL rises (sampling).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      if (start_det)                          bit_cnt <= 3'd0;
      else if (shift_en || (state == TX && scl_fall)) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shift_reg <= addr_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_oe    <= 1'b0;
      ptr_reg   <= 8'h00;
      shadow    <= 16'h0000;
      wr_strobe <= 1'b0;
      rd_done   <= 1'b0;
      busy      <= 1'b0;
      rw_q      <= 1'b0;
      lsb_sel   <= 1'b0;
      tx_acked  <= 1'b0;
    end else begin
      sda_oe    <= oe_nxt;
      wr_strobe <= ptr_load;
      rd_done   <= rd_pulse;
      tx_acked  <= (state == TX_ACK) && (tx_acked || (scl_rise && !sda_s));
      if (ptr_load) ptr_reg <= shift_reg;
      if (addr_match) begin
        rw_q    <= addr_byte[0];
        lsb_sel <= 1'b0;
        if (addr_byte[0]) shadow <= temp_data;
      end else if (byte_adv) begin
        lsb_sel <= ~lsb_sel;
      end
      if (stop_det)                                    busy <= 1'b0;
      else if (start_det)                              busy <= 1'b1;
      else if (state == ADDR && state_nxt == WAIT_STOP) busy <= 1'b0;
    end
  end

endmodule
